// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN tile output path.
// Y samples are Q9.8 signed words, 18 bits wide, sixteen cells per 4x4 tile.
package cnn_pkg;
  localparam int WIDTH = 9;
  localparam int Y_W   = 2 * WIDTH;
  localparam int CELLS = 16;
  localparam int IDX_W = 4;
  localparam int FRAC  = 8;

  typedef enum logic {ST_IDLE, ST_STREAM} unload_st_t;
  typedef logic signed [Y_W-1:0] cell_y_t;
endpackage

// File: rtl/cnn_tile_unloader_if.sv
// Valid/ready stream of one snapshot cell per beat, tagged with raster index and frame end.
// The master drives data and valid. The slave drives ready.
interface cnn_tile_unloader_if;
  import cnn_pkg::*;

  logic             valid;
  logic             ready;
  cell_y_t          data;
  logic [IDX_W-1:0] idx;
  logic             last;

  modport master (output valid, data, idx, last, input ready);
  modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/cnn_sweep_compare.sv
// Frame-to-frame convergence check. This module is built only when CNN_UNLOAD_CONV_EN is defined.
// converged goes high one cycle after a capture in which every cell moved by at most 1 LSB.
`ifdef CNN_UNLOAD_CONV_EN
module cnn_sweep_compare
  import cnn_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    capture,
  input  cell_y_t y [CELLS],
  output logic    converged
);

  localparam logic signed [Y_W:0] ONE = 1;

  cell_y_t           prev [CELLS];
  logic              have_prev;
  logic              match;
  logic signed [Y_W:0] diff;

  always_comb begin
    match = 1'b1;
    diff  = '0;
    for (int i = 0; i < CELLS; i++) begin
      diff = $signed({y[i][Y_W-1], y[i]}) - $signed({prev[i][Y_W-1], prev[i]});
      if (diff > ONE || diff < -ONE) match = 1'b0;
    end
  end

  // The first frame after reset has nothing to compare against, so it never reports converged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_prev <= 1'b0;
      converged <= 1'b0;
      for (int i = 0; i < CELLS; i++) prev[i] <= '0;
    end else if (capture) begin
      have_prev <= 1'b1;
      converged <= have_prev && match;
      for (int i = 0; i < CELLS; i++) prev[i] <= y[i];
    end
  end

endmodule
`endif

// File: rtl/cnn_tile_unloader.sv
// Snapshots 16 tile outputs on sweep_done and streams them in raster order. out_valid rises 1 cycle after capture.
// A stall holds the current beat stable. A sweep_done that arrives mid-frame is dropped and sets the overrun flag. Enable the convergence check with CNN_UNLOAD_CONV_EN.
module cnn_tile_unloader
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sweep_done,
  input  logic [CELLS*Y_W-1:0]   y_flat,
  cnn_tile_unloader_if.master    stream,
  output logic                   busy,
  output logic                   overrun,
  output logic                   converged
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

  unload_st_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  cell_y_t          snap    [CELLS];
  cell_y_t          y_cells [CELLS];
  logic             capture;
  logic             set_ovr;
  logic             fire;

  always_comb begin
    for (int i = 0; i < CELLS; i++) y_cells[i] = y_flat[i*Y_W +: Y_W];
  end

  assign fire = (state == ST_STREAM) && stream.ready;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sweep_done) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (fire && idx == LAST_IDX) begin
          // A new sweep that lands on the final beat is taken directly, so frames run back to back.
          if (sweep_done) begin
            capture = 1'b1;
            idx_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          if (fire) idx_nxt = idx + IDX_W'(1);
          set_ovr = sweep_done;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < CELLS; i++) snap[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (set_ovr) overrun <= 1'b1;
      if (capture) begin
        for (int i = 0; i < CELLS; i++) snap[i] <= y_cells[i];
      end
    end
  end

  // When no frame is streaming, the data, index and last outputs are held at zero.
  always_comb begin
    stream.valid = (state == ST_STREAM);
    stream.data  = stream.valid ? snap[idx] : '0;
    stream.idx   = stream.valid ? idx : '0;
    stream.last  = stream.valid && (idx == LAST_IDX);
  end

  assign busy = (state == ST_STREAM);

`ifdef CNN_UNLOAD_CONV_EN
  cnn_sweep_compare u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .y         (y_cells),
    .converged (converged)
  );
`else
  assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_cnn_tile_unloader.sv
// Bench for cnn_tile_unloader. A queue model of the pending beats is checked on every cycle.
// It runs table frames, hand-written corner cases, and then randomized traffic.
module tb_cnn_tile_unloader;
  import cnn_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 sweep_done;
  logic [CELLS*Y_W-1:0] y_flat;
  logic                 busy, overrun, converged;

  cnn_tile_unloader_if u_if ();

  cnn_tile_unloader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sweep_done (sweep_done),
    .y_flat     (y_flat),
    .stream     (u_if),
    .busy       (busy),
    .overrun    (overrun),
    .converged  (converged)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // The reference model is the list of beats still owed for the frame, plus the flag state.
  int ynext [CELLS];
  int base  [CELLS];
  int pend  [$];
  bit m_ovr, m_conv, m_have;
  int m_prev [CELLS];
  bit f_fire;
  int f_idx, f_data;

  typedef struct {
    int          mult;
    logic [15:0] rdy_pat;
    int          exp_first;
    int          exp_last;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CELLS*Y_W-1:0] pack_y();
    logic [CELLS*Y_W-1:0] p;
    p = '0;
    for (int k = 0; k < CELLS; k++) p[k*Y_W +: Y_W] = Y_W'(ynext[k]);
    return p;
  endfunction

  task automatic model_capture();
    bit close;
    close = 1'b1;
    for (int k = 0; k < CELLS; k++) begin
      if (ynext[k] - m_prev[k] > 1 || ynext[k] - m_prev[k] < -1) close = 1'b0;
    end
`ifdef CNN_UNLOAD_CONV_EN
    m_conv = m_have && close;
`else
    m_conv = 1'b0;
`endif
    m_have = 1'b1;
    for (int k = 0; k < CELLS; k++) begin
      m_prev[k] = ynext[k];
      pend.push_back(ynext[k]);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_ovr  = 1'b0;
    m_conv = 1'b0;
    m_have = 1'b0;
  endtask

  // Each step samples the outputs at the falling edge and then drives the inputs for the next rising edge.
  task automatic step(input logic sd, input logic rdy);
    @(negedge clk);
    chk("valid", int'(u_if.valid), int'(pend.size() > 0));
    chk("busy", int'(busy), int'(pend.size() > 0));
    chk("overrun", int'(overrun), int'(m_ovr));
    chk("converged", int'(converged), int'(m_conv));
    if (pend.size() > 0) begin
      chk("data", int'($signed(u_if.data)), pend[0]);
      chk("idx", int'(u_if.idx), CELLS - pend.size());
      chk("last", int'(u_if.last), int'(pend.size() == 1));
    end
    sweep_done = sd;
    y_flat     = pack_y();
    u_if.ready = rdy;
    f_fire = (pend.size() > 0) && rdy;
    if (f_fire) begin
      f_idx  = CELLS - pend.size();
      f_data = pend.pop_front();
    end
    if (sd) begin
      if (pend.size() == 0) model_capture();
      else m_ovr = 1'b1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && pend.size() > 0; n++) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    #2;
    rst_n      = 1'b0;
    sweep_done = 1'b0;
    #1;
    chk("rst_valid", int'(u_if.valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_idx", int'(u_if.idx), 0);
    chk("rst_data", int'($signed(u_if.data)), 0);
    chk("rst_converged", int'(converged), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_mult(input int m, input int off);
    for (int k = 0; k < CELLS; k++) ynext[k] = m * (k + 1) + off;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    int   beats, first_d, last_d;
    int   exp_c [3];
    logic signed [17:0] r;

    vecs[0] = '{mult: 3,    rdy_pat: 16'hFFFF, exp_first: 3,    exp_last: 48};
    vecs[1] = '{mult: -1,   rdy_pat: 16'h5555, exp_first: -1,   exp_last: -16};
    vecs[2] = '{mult: 100,  rdy_pat: 16'h8421, exp_first: 100,  exp_last: 1600};
    vecs[3] = '{mult: -500, rdy_pat: 16'hF0F0, exp_first: -500, exp_last: -8000};

    rst_n      = 1'b0;
    sweep_done = 1'b0;
    y_flat     = '0;
    u_if.ready = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      ynext[k] = 0; base[k] = 0; m_prev[k] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_valid", int'(u_if.valid), 0);
    chk("init_overrun", int'(overrun), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_data", int'($signed(u_if.data)), 0);
    rst_n = 1'b1;

    // Table-driven frames, each using its own ready pattern.
    for (int v = 0; v < 4; v++) begin
      set_mult(vecs[v].mult, 0);
      step(1'b1, 1'b0);
      beats = 0; first_d = 0; last_d = 0;
      for (int c = 0; c < 200 && pend.size() > 0; c++) begin
        step(1'b0, vecs[v].rdy_pat[c % 16]);
        if (f_fire) begin
          beats++;
          if (f_idx == 0)  first_d = f_data;
          if (f_idx == 15) last_d  = f_data;
        end
      end
      chk("tbl_beats", beats, 16);
      chk("tbl_first", first_d, vecs[v].exp_first);
      chk("tbl_last", last_d, vecs[v].exp_last);
      step(1'b0, 1'b1);
    end

    // A sweep_done on the final transfer starts the next frame with no bubble.
    set_mult(7, 0);
    step(1'b1, 1'b1);
    for (int b = 0; b < 15; b++) step(1'b0, 1'b1);
    set_mult(0, 1000);
    for (int k = 0; k < CELLS; k++) ynext[k] = 1000 + k + 1;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("b2b_valid", int'(u_if.valid), 1);
    chk("b2b_idx", int'(u_if.idx), 0);
    chk("b2b_data", int'($signed(u_if.data)), 1001);
    chk("b2b_overrun", int'(overrun), 0);
    drain();

    // A sweep_done at beat 5 is dropped and sets the sticky overrun flag.
    set_mult(5, 1);
    step(1'b1, 1'b1);
    for (int b = 0; b < 5; b++) step(1'b0, 1'b1);
    set_mult(-7, 0);
    step(1'b1, 1'b1);
    drain();
    chk("ovr_sticky", int'(overrun), 1);
    repeat (3) step(1'b0, 1'b1);
    chk("ovr_still", int'(overrun), 1);

    // Reset in the middle of a frame, then stream a fresh frame.
    set_mult(9, 0);
    step(1'b1, 1'b1);
    for (int b = 0; b < 8; b++) step(1'b0, 1'b1);
    do_reset();
    set_mult(11, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("post_rst_idx", int'(u_if.idx), 0);
    chk("post_rst_data", int'($signed(u_if.data)), 11);
    drain();

    // Convergence: two identical sweeps, then a third sweep with cell 3 moved by +2.
    do_reset();
`ifdef CNN_UNLOAD_CONV_EN
    exp_c = '{0, 1, 0};
`else
    exp_c = '{0, 0, 0};
`endif
    for (int f = 0; f < 3; f++) begin
      set_mult(10, 0);
      if (f == 2) ynext[2] = ynext[2] + 2;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("conv_seq", int'(converged), exp_c[f]);
      drain();
    end

    // Randomized traffic, with inputs that drift slightly so converged is exercised.
    for (int k = 0; k < CELLS; k++) begin
      r = 18'($urandom_range(0, 120000)) - 18'sd60000;
      base[k] = int'(r);
    end
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < CELLS; k++) begin
          r = 18'($urandom_range(0, 120000)) - 18'sd60000;
          base[k] = int'(r);
        end
      end
      for (int k = 0; k < CELLS; k++)
        ynext[k] = base[k] + (($urandom_range(0, 7) == 0) ? 2 : int'($urandom_range(0, 2)) - 1);
      if ($urandom_range(0, 400) == 0) do_reset();
      else step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
